// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: FSM states, ISA field
// codes, datapath selector encodings and the branch/jump condition evaluator.
package cpu_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXEC,
      WB,
      MEMRD,
      MEMWB,
      MEMWR,
      BRANCH,
      JUMP
   } state_e;

   localparam logic [3:0] OP_RTYPE   = 4'h0;
   localparam logic [3:0] OP_SPECIAL = 4'h4;
   localparam logic [3:0] OP_MOVI    = 4'hD;
   localparam logic [3:0] OP_BCOND   = 4'hC;
   localparam logic [3:0] OP_CMPI    = 4'hB;

   localparam logic [3:0] EXT_ADD   = 4'h5;
   localparam logic [3:0] EXT_CMP   = 4'hB;
   localparam logic [3:0] EXT_MOV   = 4'hD;
   localparam logic [3:0] EXT_LOAD  = 4'h0;
   localparam logic [3:0] EXT_STOR  = 4'h4;
   localparam logic [3:0] EXT_JAL   = 4'h8;
   localparam logic [3:0] EXT_JCOND = 4'hC;

   localparam logic [1:0] WD_MEM  = 2'b00;
   localparam logic [1:0] WD_PC1  = 2'b01;
   localparam logic [1:0] WD_IMM  = 2'b10;
   localparam logic [1:0] WD_ALU  = 2'b11;

   localparam logic [1:0] ALUA_PC    = 2'b00;
   localparam logic [1:0] ALUA_ZERO  = 2'b01;
   localparam logic [1:0] ALUA_RDEST = 2'b10;

   localparam logic ALUB_RSRC = 1'b0;
   localparam logic ALUB_IMM  = 1'b1;
   localparam logic MEM_PC    = 1'b0;
   localparam logic MEM_RSRC  = 1'b1;
   localparam logic PC_ALU    = 1'b0;
   localparam logic PC_RSRC   = 1'b1;
   localparam logic WA_LINK   = 1'b0;
   localparam logic WA_RDEST  = 1'b1;

   // Arithmetic/logic codes shared by the R-type opext field and the immediate opcode field.
   function automatic logic alu_code_valid(input logic [3:0] code);
      case (code)
         4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: alu_code_valid = 1'b1;
         default:                                              alu_code_valid = 1'b0;
      endcase
   endfunction

   // flags = {F,L,N,Z,C}
   function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] flags);
      logic f, l, n, z, c;
      {f, l, n, z, c} = flags;
      case (cond)
         4'h0:    cond_eval = z;
         4'h1:    cond_eval = ~z;
         4'h2:    cond_eval = c;
         4'h3:    cond_eval = ~c;
         4'h4:    cond_eval = l;
         4'h5:    cond_eval = ~l;
         4'h6:    cond_eval = n;
         4'h7:    cond_eval = ~n;
         4'h8:    cond_eval = f;
         4'h9:    cond_eval = ~f;
         4'hA:    cond_eval = ~l & ~z;
         4'hB:    cond_eval = l | z;
         4'hC:    cond_eval = ~n & ~z;
         4'hD:    cond_eval = n | z;
         4'hE:    cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_cond.sv
// Combinational condition evaluator for Bcond/Jcond: cond field against PSR flags.
module cpu_cond
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       taken
);

   always_comb begin
      taken = cond_eval(cond, flags);
   end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM with instruction register and decode.
// Optional feature: define CTRL_JAL_EN to decode JAL; otherwise JAL is a NOP.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] mem_out,
   input  logic [4:0]       flags,
   output logic             wa_s,
   output logic             pc_s,
   output logic             alub_s,
   output logic             mem_s,
   output logic [1:0]       wd_s,
   output logic [1:0]       alua_s,
   output logic             pcen,
   output logic             regwrite,
   output logic             memwrite,
   output logic             irwrite,
   output logic             signext_sign,
   output logic [3:0]       opcode,
   output logic [3:0]       opext,
   output logic [3:0]       rdest_addr,
   output logic [3:0]       rsrc_addr,
   output logic [7:0]       imm
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic             idle_q, idle_d;
   logic             cond_taken;

   logic [3:0] ir_op, ir_ext;
   logic       is_reg_alu, is_imm_alu, is_cmp, imm_form;
   logic       is_mov, is_movi, is_load, is_stor, is_jcond, is_bcond;
`ifdef CTRL_JAL_EN
   logic       is_jal;
`endif

   cpu_cond u_cond (
      .cond  (ir_q[11:8]),
      .flags (flags),
      .taken (cond_taken)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         ir_q    <= '0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         idle_q  <= idle_d;
      end
   end

   always_comb begin
      ir_op      = ir_q[15:12];
      ir_ext     = ir_q[7:4];
      imm_form   = (ir_op != OP_RTYPE);
      is_reg_alu = (ir_op == OP_RTYPE) && alu_code_valid(ir_ext);
      is_imm_alu = alu_code_valid(ir_op);
      is_cmp     = ((ir_op == OP_RTYPE) && (ir_ext == EXT_CMP)) || (ir_op == OP_CMPI);
      is_mov     = (ir_op == OP_RTYPE) && (ir_ext == EXT_MOV);
      is_movi    = (ir_op == OP_MOVI);
      is_load    = (ir_op == OP_SPECIAL) && (ir_ext == EXT_LOAD);
      is_stor    = (ir_op == OP_SPECIAL) && (ir_ext == EXT_STOR);
      is_jcond   = (ir_op == OP_SPECIAL) && (ir_ext == EXT_JCOND);
      is_bcond   = (ir_op == OP_BCOND);
`ifdef CTRL_JAL_EN
      is_jal     = (ir_op == OP_SPECIAL) && (ir_ext == EXT_JAL);
`endif
   end

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      idle_d       = 1'b0;
      wa_s         = 1'b0;
      pc_s         = 1'b0;
      alub_s       = 1'b0;
      mem_s        = 1'b0;
      wd_s         = '0;
      alua_s       = '0;
      pcen         = 1'b0;
      regwrite     = 1'b0;
      memwrite     = 1'b0;
      irwrite      = 1'b0;
      signext_sign = 1'b0;
      opcode       = ir_q[15:12];
      opext        = ir_q[7:4];
      rdest_addr   = ir_q[11:8];
      rsrc_addr    = ir_q[3:0];
      imm          = ir_q[7:0];

      // The cycle after reset is held idle so the first FETCH follows release.
      if (!idle_q) begin
         case (state_q)
            FETCH: begin
               mem_s   = MEM_PC;
               irwrite = 1'b1;
               ir_d    = mem_out;
               alua_s  = ALUA_PC;
               alub_s  = ALUB_IMM;
               imm     = 8'h01;
               opcode  = OP_RTYPE;
               opext   = EXT_ADD;
               pcen    = 1'b1;
               state_d = DECODE;
            end
            DECODE: begin
               if (is_reg_alu || is_imm_alu)  state_d = EXEC;
               else if (is_mov || is_movi)    state_d = WB;
               else if (is_load)              state_d = MEMRD;
               else if (is_stor)              state_d = MEMWR;
               else if (is_bcond)             state_d = BRANCH;
               else if (is_jcond)             state_d = JUMP;
`ifdef CTRL_JAL_EN
               else if (is_jal)               state_d = JUMP;
`endif
               else                           state_d = FETCH;
            end
            EXEC: begin
               alua_s       = ALUA_RDEST;
               alub_s       = imm_form;
               signext_sign = imm_form;
               state_d      = WB;
            end
            WB: begin
               // ALU operands stay selected so alu_out is still valid while it is written.
               if (is_mov) begin
                  alua_s   = ALUA_ZERO;
                  alub_s   = ALUB_RSRC;
                  wd_s     = WD_ALU;
                  wa_s     = WA_RDEST;
                  regwrite = 1'b1;
               end else if (is_movi) begin
                  wd_s     = WD_IMM;
                  wa_s     = WA_RDEST;
                  regwrite = 1'b1;
               end else if (!is_cmp) begin
                  alua_s       = ALUA_RDEST;
                  alub_s       = imm_form;
                  signext_sign = imm_form;
                  wd_s         = WD_ALU;
                  wa_s         = WA_RDEST;
                  regwrite     = 1'b1;
               end
               state_d = FETCH;
            end
            MEMRD: begin
               mem_s   = MEM_RSRC;
               state_d = MEMWB;
            end
            MEMWB: begin
               mem_s    = MEM_RSRC;
               wd_s     = WD_MEM;
               wa_s     = WA_RDEST;
               regwrite = 1'b1;
               state_d  = FETCH;
            end
            MEMWR: begin
               mem_s    = MEM_RSRC;
               memwrite = 1'b1;
               state_d  = FETCH;
            end
            BRANCH: begin
               opcode = OP_RTYPE;
               opext  = EXT_ADD;
               if (cond_taken) begin
                  pcen         = 1'b1;
                  pc_s         = PC_ALU;
                  alua_s       = ALUA_PC;
                  alub_s       = ALUB_IMM;
                  signext_sign = 1'b1;
               end
               state_d = FETCH;
            end
            JUMP: begin
`ifdef CTRL_JAL_EN
               if (is_jal) begin
                  pcen     = 1'b1;
                  pc_s     = PC_RSRC;
                  regwrite = 1'b1;
                  wa_s     = WA_LINK;
                  wd_s     = WD_PC1;
               end else
`endif
               if (cond_taken) begin
                  pcen = 1'b1;
                  pc_s = PC_RSRC;
               end
               state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-instruction expected output sequences
// built from the ISA rules, compared every cycle, plus hand-computed spot checks.
module tb_cpu_controller;

   typedef struct packed {
      logic       wa_s;
      logic       pc_s;
      logic       alub_s;
      logic       mem_s;
      logic [1:0] wd_s;
      logic [1:0] alua_s;
      logic       pcen;
      logic       regwrite;
      logic       memwrite;
      logic       irwrite;
      logic       signext_sign;
      logic [3:0] opcode;
      logic [3:0] opext;
      logic [3:0] rdest;
      logic [3:0] rsrc;
      logic [7:0] imm;
   } outs_t;

   logic        clk;
   logic        reset;
   logic [15:0] mem_out;
   logic [4:0]  flags;
   logic        wa_s, pc_s, alub_s, mem_s;
   logic [1:0]  wd_s, alua_s;
   logic        pcen, regwrite, memwrite, irwrite, signext_sign;
   logic [3:0]  opcode, opext, rdest_addr, rsrc_addr;
   logic [7:0]  imm;
   outs_t       act;

   int unsigned compared = 0;
   int unsigned failed   = 0;
   outs_t       exp_q[$];
   logic [15:0] last_ir;
   int unsigned n_cyc;

`ifdef CTRL_JAL_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif

   cpu_controller #(.WIDTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_out      (mem_out),
      .flags        (flags),
      .wa_s         (wa_s),
      .pc_s         (pc_s),
      .alub_s       (alub_s),
      .mem_s        (mem_s),
      .wd_s         (wd_s),
      .alua_s       (alua_s),
      .pcen         (pcen),
      .regwrite     (regwrite),
      .memwrite     (memwrite),
      .irwrite      (irwrite),
      .signext_sign (signext_sign),
      .opcode       (opcode),
      .opext        (opext),
      .rdest_addr   (rdest_addr),
      .rsrc_addr    (rsrc_addr),
      .imm          (imm)
   );

   assign act = {wa_s, pc_s, alub_s, mem_s, wd_s, alua_s, pcen, regwrite, memwrite,
                 irwrite, signext_sign, opcode, opext, rdest_addr, rsrc_addr, imm};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         outs_t e;
         e = exp_q.pop_front();
         compared++;
         if (act !== e) begin
            failed++;
            $display("FAIL cycle_outputs t=%0t ir=%h: got %h want %h", $time, last_ir, act, e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         failed++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic outs_t fields(input logic [15:0] w);
      outs_t o;
      o = '0;
      o.opcode = w[15:12];
      o.rdest  = w[11:8];
      o.opext  = w[7:4];
      o.rsrc   = w[3:0];
      o.imm    = w[7:0];
      return o;
   endfunction

   // Conditions 0..9 are pairs (flag true, flag false) over Z,C,L,N,F.
   function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
      int unsigned sel [5];
      sel = '{1, 0, 3, 2, 4};
      if (c < 4'd10) return f[sel[c / 2]] ^ c[0];
      case (c)
         4'd10:   return !f[3] && !f[1];
         4'd11:   return f[3] || f[1];
         4'd12:   return !f[2] && !f[1];
         4'd13:   return f[2] || f[1];
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_push(input logic [15:0] ins, input logic [4:0] f, output int unsigned n);
      outs_t       b, e;
      logic [3:0]  op, ext, alu_code;
      logic        form;
      int unsigned start;
      start = exp_q.size();
      op    = ins[15:12];
      ext   = ins[7:4];
      e = fields(last_ir);
      e.opcode = 4'h0; e.opext = 4'h5; e.imm = 8'h01;
      e.irwrite = 1'b1; e.pcen = 1'b1; e.alub_s = 1'b1;
      exp_q.push_back(e);
      last_ir = ins;
      b = fields(ins);
      exp_q.push_back(b);
      form     = (op != 4'h0);
      alu_code = form ? op : ext;
      if (alu_code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB}) begin
         e = b; e.alua_s = 2'd2; e.alub_s = form; e.signext_sign = form;
         exp_q.push_back(e);
         if (alu_code == 4'hB) exp_q.push_back(b);
         else begin
            e.regwrite = 1'b1; e.wa_s = 1'b1; e.wd_s = 2'd3;
            exp_q.push_back(e);
         end
      end else if (op == 4'h0 && ext == 4'hD) begin
         e = b; e.regwrite = 1'b1; e.wa_s = 1'b1; e.wd_s = 2'd3; e.alua_s = 2'd1;
         exp_q.push_back(e);
      end else if (op == 4'hD) begin
         e = b; e.regwrite = 1'b1; e.wa_s = 1'b1; e.wd_s = 2'd2;
         exp_q.push_back(e);
      end else if (op == 4'h4 && ext == 4'h0) begin
         e = b; e.mem_s = 1'b1;
         exp_q.push_back(e);
         e.regwrite = 1'b1; e.wa_s = 1'b1; e.wd_s = 2'd0;
         exp_q.push_back(e);
      end else if (op == 4'h4 && ext == 4'h4) begin
         e = b; e.mem_s = 1'b1; e.memwrite = 1'b1;
         exp_q.push_back(e);
      end else if (op == 4'hC) begin
         e = b; e.opcode = 4'h0; e.opext = 4'h5;
         if (cond_true(ins[11:8], f)) begin
            e.pcen = 1'b1; e.alub_s = 1'b1; e.signext_sign = 1'b1;
         end
         exp_q.push_back(e);
      end else if (op == 4'h4 && ext == 4'hC) begin
         e = b;
         if (cond_true(ins[11:8], f)) begin
            e.pcen = 1'b1; e.pc_s = 1'b1;
         end
         exp_q.push_back(e);
      end else if (op == 4'h4 && ext == 4'h8 && JAL_EN) begin
         e = b; e.pcen = 1'b1; e.pc_s = 1'b1; e.regwrite = 1'b1; e.wd_s = 2'd1;
         exp_q.push_back(e);
      end
      n = exp_q.size() - start;
   endtask

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [15:0] ins, input logic [4:0] f, output int unsigned n);
      mem_out = ins;
      flags   = f;
      model_push(ins, f, n);
   endtask

   task automatic run(input logic [15:0] ins, input logic [4:0] f);
      int unsigned n;
      issue(ins, f, n);
      step(n);
   endtask

   logic [15:0] vec_i [16];
   logic [4:0]  vec_f [16];

   initial begin
      vec_i = '{16'h0391, 16'h02B1, 16'hB205, 16'h03D4, 16'hD37F, 16'h3180, 16'h4EC5, 16'h4FC5,
                16'h41C5, 16'hCAF0, 16'hCBF0, 16'hCD10, 16'hC810, 16'hC310, 16'h8000, 16'h4010};
      vec_f = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F,
                5'h00, 5'h00, 5'h00, 5'h04, 5'h10, 5'h01, 5'h00, 5'h00};
      reset   = 1'b1;
      mem_out = '0;
      flags   = '0;
      last_ir = '0;

      step(1);
      chk("reset_outputs_zero", 32'(act), 32'd0);
      chk("reset_imm_zero", 32'(imm), 32'd0);
      exp_q.push_back('0);
      step(1);
      reset = 1'b0;
      exp_q.push_back('0);
      step(1);
      chk("first_fetch_irwrite", 32'(irwrite), 32'd1);
      chk("first_fetch_pcen", 32'(pcen), 32'd1);

      // ADD r2,r1
      issue(16'h0251, 5'h00, n_cyc);
      chk("add_len", n_cyc, 4);
      step(3);
      chk("add_wb_regwrite", 32'(regwrite), 32'd1);
      chk("add_wb_wd_s", 32'(wd_s), 32'd3);
      chk("add_wb_wa_s", 32'(wa_s), 32'd1);
      chk("add_wb_opcode", 32'(opcode), 32'd0);
      chk("add_wb_opext", 32'(opext), 32'd5);
      step(1);

      // ADDI r2,#12
      issue(16'h520C, 5'h00, n_cyc);
      step(2);
      chk("addi_exec_alub_s", 32'(alub_s), 32'd1);
      chk("addi_exec_imm", 32'(imm), 32'h0C);
      chk("addi_exec_signext", 32'(signext_sign), 32'd1);
      step(1);
      chk("addi_wb_regwrite", 32'(regwrite), 32'd1);
      step(1);

      // LOAD r3,[r4]
      issue(16'h4304, 5'h00, n_cyc);
      step(2);
      chk("load_memrd_mem_s", 32'(mem_s), 32'd1);
      step(1);
      chk("load_memwb_regwrite", 32'(regwrite), 32'd1);
      chk("load_memwb_wd_s", 32'(wd_s), 32'd0);
      step(1);

      // STOR: memwrite only in its single MEMWR cycle
      issue(16'h4344, 5'h00, n_cyc);
      chk("stor_len", n_cyc, 3);
      step(1);
      chk("stor_decode_memwrite", 32'(memwrite), 32'd0);
      step(1);
      chk("stor_memwr_memwrite", 32'(memwrite), 32'd1);
      step(1);
      chk("stor_after_memwrite", 32'(memwrite), 32'd0);

      // BEQ -2, taken then not taken
      issue(16'hC0FE, 5'b00010, n_cyc);
      step(2);
      chk("beq_taken_pcen", 32'(pcen), 32'd1);
      chk("beq_taken_pc_s", 32'(pc_s), 32'd0);
      step(1);
      issue(16'hC0FE, 5'b00000, n_cyc);
      step(2);
      chk("beq_not_taken_pcen", 32'(pcen), 32'd0);
      step(1);
      chk("beq_not_taken_next_fetch", 32'(irwrite), 32'd1);

      // JAL r15,r5
      issue(16'h4F85, 5'h00, n_cyc);
      step(1);
      chk("jal_decode_regwrite", 32'(regwrite), 32'd0);
      if (JAL_EN) begin
         step(1);
         chk("jal_pcen", 32'(pcen), 32'd1);
         chk("jal_pc_s", 32'(pc_s), 32'd1);
         chk("jal_regwrite", 32'(regwrite), 32'd1);
         chk("jal_wa_s", 32'(wa_s), 32'd0);
         chk("jal_wd_s", 32'(wd_s), 32'd1);
         step(1);
      end else begin
         step(1);
         chk("jal_disabled_refetch", 32'(irwrite), 32'd1);
      end

      for (int i = 0; i < 16; i++) run(vec_i[i], vec_f[i]);

      // Reset asserted while in MEMWR
      issue(16'h4344, 5'h00, n_cyc);
      step(2);
      chk("midwr_memwrite_before", 32'(memwrite), 32'd1);
      reset = 1'b1;
      exp_q.push_back('0);
      step(1);
      last_ir = '0;
      chk("midwr_memwrite_dropped", 32'(memwrite), 32'd0);
      chk("midwr_regwrite_zero", 32'(regwrite), 32'd0);
      reset = 1'b0;
      step(1);
      chk("midwr_fetch_after_release", 32'(irwrite), 32'd1);
      run(16'h0251, 5'h00);

      chk("expect_queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
